// File: rtl/text_msg_ctrl_pkg.sv
// Shared types and defaults for the text overlay controller: game modes, message ids, FSM states.
package text_msg_ctrl_pkg;

  typedef enum logic [1:0] {
    GAME_MODE_LOADING,
    GAME_MODE_READY,
    GAME_MODE_PLAYING,
    GAME_MODE_OVER
  } game_mode_t;

  typedef enum logic [1:0] {
    MSG_NONE,
    MSG_LOADING,
    MSG_READY,
    MSG_GAMEOVER
  } text_msg_t;

  typedef enum logic [1:0] {
    S_LOADING,
    S_READY,
    S_PLAY,
    S_OVER
  } state_t;

  localparam int DEF_SCORE_W      = 16;
  localparam int DEF_BLINK_FRAMES = 16;
  localparam int DEF_HOLD_FRAMES  = 180;

  // Message shown in the centre slot for each controller state.
  function automatic text_msg_t state_msg(input state_t s);
    case (s)
      S_LOADING: return MSG_LOADING;
      S_READY:   return MSG_READY;
      S_OVER:    return MSG_GAMEOVER;
      default:   return MSG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/text_msg_ctrl_if.sv
// Bundle between game-mode logic (master) and the overlay controller (slave).
interface text_msg_ctrl_if
  import text_msg_ctrl_pkg::*;
#(
  parameter int SCORE_W = DEF_SCORE_W
);
  logic               frame_tick;
  game_mode_t         MODE;
  logic [SCORE_W-1:0] score;
  text_msg_t          msg_id;
  logic               msg_visible;
  logic [SCORE_W-1:0] disp_score;
  logic [SCORE_W-1:0] hiscore;
  logic               hiscore_new;
  logic               hold_done;

  modport master (
    output frame_tick, MODE, score,
    input  msg_id, msg_visible, disp_score, hiscore, hiscore_new, hold_done
  );

  modport slave (
    input  frame_tick, MODE, score,
    output msg_id, msg_visible, disp_score, hiscore, hiscore_new, hold_done
  );
endinterface

// File: rtl/text_msg_ctrl_frame_counter.sv
// Tick-enabled modulo-LIMIT counter; o_wrap flags the enabled cycle in which it rolls over.
module frame_counter #(
  parameter  int LIMIT = 16,
  localparam int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap
);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = i_en && (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (o_wrap)  r_cnt <= '0;
    else if (i_en)    r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/text_msg_ctrl.sv
// Frame-synchronous overlay sequencer: message select, READY blink, GAME OVER hold, score snapshot and high score.
module text_msg_ctrl
  import text_msg_ctrl_pkg::*;
#(
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
  input logic             clk,
  input logic             rst_n,
  text_msg_ctrl_if.slave  bus
);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  state_t             r_state, w_next_state;
  text_msg_t          r_msg_id;
  logic               r_msg_visible, w_next_visible;
  logic [SCORE_W-1:0] r_disp_score, r_hiscore;
  logic               r_hiscore_new, r_hold_done;
  logic               w_hold_fire, w_entering;
  logic               w_blink_en, w_blink_wrap, w_hold_en, w_hold_wrap;
  logic [BW-1:0]      w_blink_cnt;
  logic [HW-1:0]      w_hold_cnt;

  assign w_blink_en = bus.frame_tick && (r_state == S_READY);
  assign w_hold_en  = bus.frame_tick && (r_state == S_OVER);
  assign w_entering = (w_next_state != r_state);

  frame_counter #(.LIMIT(BLINK_FRAMES)) u_blink (
    .clk(clk), .rst_n(rst_n), .i_en(w_blink_en),
    .i_clr(w_entering && (w_next_state == S_READY)),
    .o_cnt(w_blink_cnt), .o_wrap(w_blink_wrap)
  );

  frame_counter #(.LIMIT(HOLD_FRAMES)) u_hold (
    .clk(clk), .rst_n(rst_n), .i_en(w_hold_en),
    .i_clr(w_entering && (w_next_state == S_OVER)),
    .o_cnt(w_hold_cnt), .o_wrap(w_hold_wrap)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_hold_fire    = 1'b0;
    if (bus.frame_tick) begin
      unique case (r_state)
        S_LOADING: if (bus.MODE == GAME_MODE_READY) w_next_state = S_READY;
        S_READY: begin
          if (bus.MODE == GAME_MODE_PLAYING)      w_next_state = S_PLAY;
          else if (bus.MODE == GAME_MODE_LOADING) w_next_state = S_LOADING;
        end
        S_PLAY: begin
          if (bus.MODE == GAME_MODE_OVER)         w_next_state = S_OVER;
          else if (bus.MODE == GAME_MODE_LOADING) w_next_state = S_LOADING;
        end
        S_OVER: begin
          // LOADING aborts the hold outright; expiry beats an early READY so the pulse is not lost.
          if (bus.MODE == GAME_MODE_LOADING) w_next_state = S_LOADING;
          else if (w_hold_wrap) begin
            w_next_state = S_READY;
            w_hold_fire  = 1'b1;
          end else if (bus.MODE == GAME_MODE_READY) w_next_state = S_READY;
        end
        default: w_next_state = S_LOADING;
      endcase
    end

    w_next_visible = r_msg_visible;
    if (w_entering)                              w_next_visible = (w_next_state != S_PLAY);
    else if (r_state == S_READY && w_blink_wrap) w_next_visible = ~r_msg_visible;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_LOADING;
      r_msg_id      <= MSG_LOADING;
      r_msg_visible <= 1'b1;
      r_hold_done   <= 1'b0;
    end else begin
      r_hold_done <= w_hold_fire;
      if (bus.frame_tick) begin
        r_state       <= w_next_state;
        r_msg_id      <= state_msg(w_next_state);
        r_msg_visible <= w_next_visible;
      end
    end
  end

  // Snapshot and high score; a beaten score in the same tick wins over the new-game clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_score  <= '0;
      r_hiscore     <= '0;
      r_hiscore_new <= 1'b0;
    end else if (bus.frame_tick) begin
      r_disp_score <= bus.score;
      if (bus.score > r_hiscore) begin
        r_hiscore     <= bus.score;
        r_hiscore_new <= 1'b1;
      end else if (r_state == S_OVER && w_next_state == S_READY) begin
        r_hiscore_new <= 1'b0;
      end
    end
  end

  assign bus.msg_id      = r_msg_id;
  assign bus.msg_visible = r_msg_visible;
  assign bus.disp_score  = r_disp_score;
  assign bus.hiscore     = r_hiscore;
  assign bus.hiscore_new = r_hiscore_new;
  assign bus.hold_done   = r_hold_done;
endmodule

// File: tb/tb_text_msg_ctrl.sv
// Directed bench for text_msg_ctrl: blink, snapshot, hold expiry, early exit, async reset and high-score edges.
module tb_text_msg_ctrl;
  import text_msg_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  text_msg_ctrl_if #(.SCORE_W(16)) bus ();

  text_msg_ctrl #(.SCORE_W(16), .BLINK_FRAMES(16), .HOLD_FRAMES(180)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Holds frame_tick high for n consecutive cycles; returns at a negedge with outputs settled.
  task automatic tick_n(input int n);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame_tick = 1'b0;
    bus.MODE = GAME_MODE_LOADING;
    bus.score = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.msg_id !== MSG_LOADING) begin $display("FAIL rst_msg: got %0d want %0d", bus.msg_id, MSG_LOADING); n_fail++; end n_chk++;
    if (bus.msg_visible !== 1'b1) begin $display("FAIL rst_vis: got %b want 1", bus.msg_visible); n_fail++; end n_chk++;
    if (bus.disp_score !== 16'h0) begin $display("FAIL rst_disp: got %h want 0000", bus.disp_score); n_fail++; end n_chk++;
    if (bus.hiscore !== 16'h0) begin $display("FAIL rst_hi: got %h want 0000", bus.hiscore); n_fail++; end n_chk++;
    if (bus.hiscore_new !== 1'b0 || bus.hold_done !== 1'b0) begin
      $display("FAIL rst_flags: got new=%b done=%b want 0 0", bus.hiscore_new, bus.hold_done); n_fail++; end n_chk++;
    bus.MODE = GAME_MODE_PLAYING;
    tick_n(1);
    if (bus.msg_id !== MSG_LOADING) begin $display("FAIL loading_ignores_play: got %0d want %0d", bus.msg_id, MSG_LOADING); n_fail++; end n_chk++;
  endtask

  task automatic test_ready_blink();
    bus.MODE = GAME_MODE_READY;
    tick_n(1);
    if (bus.msg_id !== MSG_READY) begin $display("FAIL ready_msg: got %0d want %0d", bus.msg_id, MSG_READY); n_fail++; end n_chk++;
    if (bus.msg_visible !== 1'b1) begin $display("FAIL ready_vis_entry: got %b want 1", bus.msg_visible); n_fail++; end n_chk++;
    tick_n(15);
    if (bus.msg_visible !== 1'b1) begin $display("FAIL blink_15: got %b want 1", bus.msg_visible); n_fail++; end n_chk++;
    tick_n(1);
    if (bus.msg_visible !== 1'b0) begin $display("FAIL blink_16: got %b want 0", bus.msg_visible); n_fail++; end n_chk++;
    tick_n(15);
    if (bus.msg_visible !== 1'b0) begin $display("FAIL blink_31: got %b want 0", bus.msg_visible); n_fail++; end n_chk++;
    tick_n(1);
    if (bus.msg_visible !== 1'b1) begin $display("FAIL blink_32: got %b want 1", bus.msg_visible); n_fail++; end n_chk++;
  endtask

  task automatic test_score_snapshot();
    bus.MODE = GAME_MODE_PLAYING;
    bus.score = 16'h0120;
    tick_n(1);
    if (bus.msg_id !== MSG_NONE || bus.msg_visible !== 1'b0) begin
      $display("FAIL play_msg: got id=%0d vis=%b want 0 0", bus.msg_id, bus.msg_visible); n_fail++; end n_chk++;
    bus.score = 16'h0130;
    repeat (3) @(negedge clk);
    if (bus.disp_score !== 16'h0120) begin $display("FAIL snap_hold: got %h want 0120", bus.disp_score); n_fail++; end n_chk++;
    if (bus.hiscore !== 16'h0120) begin $display("FAIL snap_hi_hold: got %h want 0120", bus.hiscore); n_fail++; end n_chk++;
    tick_n(1);
    if (bus.disp_score !== 16'h0130) begin $display("FAIL snap_upd: got %h want 0130", bus.disp_score); n_fail++; end n_chk++;
    if (bus.hiscore !== 16'h0130 || bus.hiscore_new !== 1'b1) begin
      $display("FAIL snap_hi: got %h new=%b want 0130 1", bus.hiscore, bus.hiscore_new); n_fail++; end n_chk++;
  endtask

  task automatic test_hold_expire();
    bus.MODE = GAME_MODE_OVER;
    tick_n(1);
    if (bus.msg_id !== MSG_GAMEOVER || bus.msg_visible !== 1'b1) begin
      $display("FAIL over_msg: got id=%0d vis=%b want %0d 1", bus.msg_id, bus.msg_visible, MSG_GAMEOVER); n_fail++; end n_chk++;
    tick_n(179);
    if (bus.hold_done !== 1'b0 || bus.msg_id !== MSG_GAMEOVER) begin
      $display("FAIL hold_179: got done=%b id=%0d want 0 %0d", bus.hold_done, bus.msg_id, MSG_GAMEOVER); n_fail++; end n_chk++;
    tick_n(1);
    if (bus.hold_done !== 1'b1) begin $display("FAIL hold_fire: got %b want 1", bus.hold_done); n_fail++; end n_chk++;
    if (bus.msg_id !== MSG_READY || bus.msg_visible !== 1'b1) begin
      $display("FAIL hold_to_ready: got id=%0d vis=%b want %0d 1", bus.msg_id, bus.msg_visible, MSG_READY); n_fail++; end n_chk++;
    if (bus.hiscore_new !== 1'b0) begin $display("FAIL hold_new_clr: got %b want 0", bus.hiscore_new); n_fail++; end n_chk++;
    @(negedge clk);
    if (bus.hold_done !== 1'b0) begin $display("FAIL hold_pulse_width: got %b want 0", bus.hold_done); n_fail++; end n_chk++;
  endtask

  task automatic test_early_ready();
    bus.MODE = GAME_MODE_PLAYING;
    bus.score = 16'h0200;
    tick_n(1);
    if (bus.hiscore_new !== 1'b1) begin $display("FAIL early_new_set: got %b want 1", bus.hiscore_new); n_fail++; end n_chk++;
    bus.MODE = GAME_MODE_OVER;
    tick_n(51);
    bus.MODE = GAME_MODE_READY;
    tick_n(1);
    if (bus.hold_done !== 1'b0) begin $display("FAIL early_no_done: got %b want 0", bus.hold_done); n_fail++; end n_chk++;
    if (bus.msg_id !== MSG_READY || bus.msg_visible !== 1'b1) begin
      $display("FAIL early_ready: got id=%0d vis=%b want %0d 1", bus.msg_id, bus.msg_visible, MSG_READY); n_fail++; end n_chk++;
    if (bus.hiscore_new !== 1'b0) begin $display("FAIL early_new_clr: got %b want 0", bus.hiscore_new); n_fail++; end n_chk++;
    tick_n(15);
    if (bus.msg_visible !== 1'b1) begin $display("FAIL early_blink_15: got %b want 1", bus.msg_visible); n_fail++; end n_chk++;
    tick_n(1);
    if (bus.msg_visible !== 1'b0) begin $display("FAIL early_blink_16: got %b want 0", bus.msg_visible); n_fail++; end n_chk++;
  endtask

  task automatic test_back_to_back();
    bus.MODE = GAME_MODE_OVER;
    tick_n(3);
    if (bus.msg_id !== MSG_READY || bus.msg_visible !== 1'b0) begin
      $display("FAIL ready_ignores_over: got id=%0d vis=%b want %0d 0", bus.msg_id, bus.msg_visible, MSG_READY); n_fail++; end n_chk++;
    bus.MODE = GAME_MODE_LOADING;
    tick_n(1);
    if (bus.msg_id !== MSG_LOADING || bus.msg_visible !== 1'b1) begin
      $display("FAIL ready_to_loading: got id=%0d vis=%b want %0d 1", bus.msg_id, bus.msg_visible, MSG_LOADING); n_fail++; end n_chk++;
    bus.MODE = GAME_MODE_READY;
    tick_n(1);
    if (bus.msg_id !== MSG_READY || bus.msg_visible !== 1'b1) begin
      $display("FAIL loading_to_ready: got id=%0d vis=%b want %0d 1", bus.msg_id, bus.msg_visible, MSG_READY); n_fail++; end n_chk++;
  endtask

  task automatic test_reset_mid_hold();
    bus.MODE = GAME_MODE_PLAYING;
    tick_n(1);
    bus.MODE = GAME_MODE_OVER;
    tick_n(100);
    #2 rst_n = 1'b0;
    #1;
    if (bus.msg_id !== MSG_LOADING || bus.msg_visible !== 1'b1) begin
      $display("FAIL async_msg: got id=%0d vis=%b want %0d 1", bus.msg_id, bus.msg_visible, MSG_LOADING); n_fail++; end n_chk++;
    if (bus.hiscore !== 16'h0 || bus.disp_score !== 16'h0) begin
      $display("FAIL async_scores: got hi=%h disp=%h want 0000 0000", bus.hiscore, bus.disp_score); n_fail++; end n_chk++;
    if (bus.hiscore_new !== 1'b0 || bus.hold_done !== 1'b0) begin
      $display("FAIL async_flags: got new=%b done=%b want 0 0", bus.hiscore_new, bus.hold_done); n_fail++; end n_chk++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick_n(85);
    if (bus.msg_id !== MSG_LOADING || bus.hold_done !== 1'b0) begin
      $display("FAIL post_rst_no_hold: got id=%0d done=%b want %0d 0", bus.msg_id, bus.hold_done, MSG_LOADING); n_fail++; end n_chk++;
  endtask

  task automatic test_hiscore_boundary();
    bus.score = 16'hFFFE;
    tick_n(1);
    if (bus.hiscore !== 16'hFFFE || bus.hiscore_new !== 1'b1) begin
      $display("FAIL hi_fffe: got %h new=%b want fffe 1", bus.hiscore, bus.hiscore_new); n_fail++; end n_chk++;
    bus.score = 16'hFFFF;
    tick_n(1);
    if (bus.hiscore !== 16'hFFFF) begin $display("FAIL hi_ffff: got %h want ffff", bus.hiscore); n_fail++; end n_chk++;
    bus.score = 16'h0000;
    tick_n(1);
    if (bus.hiscore !== 16'hFFFF) begin $display("FAIL hi_keep: got %h want ffff", bus.hiscore); n_fail++; end n_chk++;
    if (bus.disp_score !== 16'h0000) begin $display("FAIL hi_disp_zero: got %h want 0000", bus.disp_score); n_fail++; end n_chk++;
  endtask

  initial begin
    test_reset();
    test_ready_blink();
    test_score_snapshot();
    test_hold_expire();
    test_early_ready();
    test_back_to_back();
    test_reset_mid_hold();
    test_hiscore_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
